// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock,
// LSB first, through a single full-subtractor cell. Valid/ready handshakes on
// both sides; the result is held in DONE until consumed.
// Optional: define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed
// overflow output ovf.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] res_sh_q;
   logic [WIDTH-1:0] diff_q;
   logic [CW-1:0]    cnt_q;
   logic             brw_q;
   logic             bout_q;

   logic             d_bit;
   logic             brw_nxt;
   logic             last_bit;
   logic             accept;
   logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic ovf_q;
`endif

   // Full-subtractor cell acting on the current LSBs of the operand shifters.
   always_comb begin
      d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
      brw_nxt  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
      res_nxt  = {d_bit, res_sh_q[WIDTH-1:1]};
      last_bit = (cnt_q == LastCnt);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            busy = 1'b1;
            if (last_bit) begin
               state_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath: operand/result shifters, borrow, bit counter and held result.
   // diff is a separate register so it stays stable while the next op shifts.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         brw_q    <= 1'b0;
         bout_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  a_sh_q   <= a;
                  b_sh_q   <= b;
                  brw_q    <= bin;
                  res_sh_q <= '0;
                  cnt_q    <= '0;
               end
            end
            StRun: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               brw_q    <= brw_nxt;
               res_sh_q <= res_nxt;
               cnt_q    <= cnt_q + CW'(1);
               if (last_bit) begin
                  diff_q <= res_nxt;
                  bout_q <= brw_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  // Borrow into the MSB vs. borrow out of it.
                  ovf_q  <= brw_q ^ brw_nxt;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, backpressure,
// mid-run reset and a randomized regression against an arithmetic model.
// Define SERIAL_SUBTRACTOR_OVF_EN to also check the ovf output.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         busy;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   int n_pass  = 0;
   int n_total = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .busy      (busy)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin, output logic [W-1:0] md,
                                 output logic mbo, output logic mov);
      int ua, ub, sa, sb, r, lo, hi;
      ua  = int'(ma);
      ub  = int'(mb);
      r   = ua - ub - int'(mbin);
      md  = W'(r);
      mbo = (r < 0);
      sa  = ma[W-1] ? ua - (1 << W) : ua;
      sb  = mb[W-1] ? ub - (1 << W) : ub;
      r   = sa - sb - int'(mbin);
      lo  = -(1 << (W - 1));
      hi  = (1 << (W - 1)) - 1;
      mov = (r < lo) || (r > hi);
   endfunction

   // One full operation: accept, check RUN latency, stall, check, consume.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input int stall, input string tag);
      logic [W-1:0] ed;
      logic         eb, eo;
      model(ta, tb, tbin, ed, eb, eo);
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL %s in_ready_before_accept: got %b want 1", tag, in_ready);
      else n_pass++;
      a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= int'(W); k++) begin
         in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         out_ready = 1'($urandom);
         n_total++;
         if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL %s run_flags k=%0d: got busy=%b ov=%b ir=%b want 1 0 0",
                     tag, k, busy, out_valid, in_ready);
         end else n_pass++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      n_total++;
      if (out_valid !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL %s done_latency: got ov=%b busy=%b want 1 0", tag, out_valid, busy);
      end else n_pass++;
      n_total++;
      if (diff !== ed || bout !== eb) begin
         $display("FAIL %s result a=%h b=%h bin=%b: got diff=%h bout=%b want %h %b",
                  tag, ta, tb, tbin, diff, bout, ed, eb);
      end else n_pass++;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      n_total++;
      if (ovf !== eo) $display("FAIL %s ovf: got %b want %b", tag, ovf, eo);
      else n_pass++;
`endif
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
         @(negedge clk);
         n_total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed || bout !== eb) begin
            $display("FAIL %s stall s=%0d: got ov=%b ir=%b diff=%h bout=%b want 1 0 %h %b",
                     tag, s, out_valid, in_ready, diff, bout, ed, eb);
         end else n_pass++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== ed || bout !== eb) begin
         $display("FAIL %s consume: got ov=%b ir=%b diff=%h bout=%b want 0 1 %h %b",
                  tag, out_valid, in_ready, diff, bout, ed, eb);
      end else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || diff !== '0 ||
          bout !== 1'b0) begin
         $display("FAIL reset: got ir=%b ov=%b busy=%b diff=%h bout=%b want 1 0 0 00 0",
                  in_ready, out_valid, busy, diff, bout);
      end else n_pass++;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      n_total++;
      if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
      else n_pass++;
`endif
   endtask

   task automatic test_directed();
      do_op(8'h5A, 8'h3C, 1'b0, 0, "dir_5a_3c");
      do_op(8'h00, 8'h01, 1'b0, 0, "dir_00_01");
      do_op(8'h10, 8'h0F, 1'b1, 0, "dir_10_0f_bin");
      do_op(8'h80, 8'h01, 1'b0, 0, "dir_80_01");
      do_op(8'h7F, 8'hFF, 1'b0, 0, "dir_7f_ff");
      do_op(8'h00, 8'hFF, 1'b1, 0, "dir_00_ff_bin");
   endtask

   task automatic test_backpressure();
      do_op(8'hA5, 8'h5A, 1'b1, 5, "bp_first");
      do_op(8'h33, 8'h44, 1'b0, 0, "bp_next");
   endtask

   task automatic test_reset_mid_run();
      a = 8'hFF; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || diff !== '0 ||
          bout !== 1'b0) begin
         $display("FAIL mid_reset: got ov=%b busy=%b ir=%b diff=%h bout=%b want 0 0 1 00 0",
                  out_valid, busy, in_ready, diff, bout);
      end else n_pass++;
      do_op(8'hC3, 8'h42, 1'b0, 1, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 1000; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes diff = a - b - bin one bit per clock, LSB first, using a single full-subtractor cell (difference/borrow).
- Inverse-direction companion to the team's ripple adder library; used where area matters more than latency.
- Valid/ready handshakes on both the operand side and the result side; the result is held until consumed.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, bin are valid this cycle
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  diff/bout hold a completed result
- out_ready  input  1  consumer takes the result this cycle
- diff  output  WIDTH  difference a - b - bin mod 2^WIDTH
- bout  output  1  borrow out; 1 when a < b + bin, unsigned
- busy  output  1  high in RUN

Behaviour:
- Clock and reset: single clock domain; rst is sampled on the clk rising edge only.
- Reset values: in_ready=1, out_valid=0, busy=0, diff=0, bout=0, FSM=IDLE, counter=0, internal borrow=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a and b into shift registers, load internal borrow with bin, clear the bit counter, go to RUN.
  - Operands are sampled only on the accept edge; later changes on a, b, bin are ignored.
- RUN: each cycle processes operand bit k (LSB first):
  - d = a_k ^ b_k ^ brw
  - brw' = (~a_k & b_k) | (~(a_k ^ b_k) & brw)
  - d shifts into the MSB of the result register; the result register shifts right; the operand registers shift right; counter increments.
  - After WIDTH RUN cycles, go to DONE.
  - The result register drives diff and is loaded with the final value on the edge entering DONE; bout <= final brw.
- DONE:
  - out_valid=1; diff and bout are stable.
  - On out_ready: go to IDLE, out_valid drops next cycle.
  - diff and bout keep their last value until the next completion.
- Latency:
  - Operands accepted at edge E0; out_valid is high from edge E_WIDTH.
  - Minimum operation period is WIDTH+2 cycles: accept, WIDTH RUN cycles, one DONE cycle with out_ready=1.
- Back-to-back: in_ready=0 in DONE, so no accept in the same cycle as the result handshake. A new accept is possible in the first IDLE cycle.
- Backpressure: DONE holds indefinitely while out_ready=0; no result is lost or overwritten.
- out_ready outside DONE: ignored.
- in_valid outside IDLE: ignored; no queueing.
- Reset mid-operation:
  - rst overrides everything in any state; any in-flight operation is discarded.
  - Outputs take reset values on the next edge.
- Arithmetic:
  - diff == (a - b - bin) mod 2^WIDTH.
  - bout == 1 iff {1'b0,a} < {1'b0,b} + bin.
  - Exhaustively equal to a parallel reference subtractor.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): signed overflow of a - b - bin.
  - ovf = borrow into MSB XOR borrow out of MSB.
  - Registered and updated together with bout on entry to DONE; reset value 0; held like diff.
- Not defined: port ovf absent; no overflow logic is built.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, accepted at E0 -> out_valid high from E8, diff=0x1E, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- With OVF_EN: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after completion, toggle a/b/in_valid -> diff/bout/out_valid stable, in_ready=0. Pulse out_ready -> in_ready=1 next cycle, and the next operand is accepted and computed correctly.
- Reset mid-run: assert rst for 1 cycle at the 3rd RUN cycle -> next cycle out_valid=0, busy=0, in_ready=1, diff=0. A subsequent a=0xC3, b=0x42 gives diff=0x81, bout=0.
- Random regression: 1000 random a/b/bin with random out_ready stalls -> every result matches a - b - bin and the borrow/overflow equations; one result per accepted operand, in order.
